// File: rtl/mont_redc.sv
// Limb-serial Montgomery reduction: r_out = t * 2^(-width*S) mod p, fully reduced.
// A single width x width multiplier is shared by the quotient-digit and MAC steps.
module mont_redc #(
  parameter int width = 32,
  parameter int S     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*S-1:0][width-1:0] t,
  input  logic [S-1:0][width-1:0]   p,
  input  logic [width-1:0]          p_inv,
  output logic                      busy,
  output logic                      done,
  output logic [S-1:0][width-1:0]   r_out
);
  localparam int IW  = $clog2(2*S+1);
  localparam int JW  = $clog2(S+1);
  localparam int JLW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [2:0] {IDLE, MCALC, MAC, PROP, SUB, FIN} state_t;
  state_t state, state_nxt;

  logic [2*S:0][width-1:0] a;
  logic [S-1:0][width-1:0] p_r, d;
  logic [width-1:0]        pinv_r, m, c;
  logic [IW-1:0]           i, idx;
  logic [JW-1:0]           j;
  logic [JLW-1:0]          jl;
  logic                    bor;

  logic [width-1:0]        a_cur, mul_a, mul_b, p_j;
  logic [2*width-1:0]      prod, acc;
  logic [width:0]          dif;
  logic                    last_mac, last_prop, last_i, last_sub;

  assign jl        = j[JLW-1:0];
  assign a_cur     = a[idx];
  // The modulus is zero-extended by one limb for the top subtraction step.
  assign p_j       = (j == JW'(S)) ? '0 : p_r[jl];
  assign last_mac  = (j == JW'(S-1));
  assign last_prop = (idx == IW'(2*S));
  assign last_i    = (i == IW'(S-1));
  assign last_sub  = (j == JW'(S));

  assign mul_a = (state == MCALC) ? a_cur  : m;
  assign mul_b = (state == MCALC) ? pinv_r : p_j;
  assign prod  = {{width{1'b0}}, mul_a} * {{width{1'b0}}, mul_b};

  // MAC and carry propagation share one adder; PROP just masks the product.
  assign acc = ((state == MAC) ? prod : '0)
             + {{width{1'b0}}, a_cur} + {{width{1'b0}}, c};
  assign dif = {1'b0, a_cur} - {1'b0, p_j} - {{width{1'b0}}, bor};

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    case (state)
      IDLE:    if (start) state_nxt = MCALC;
      MCALC:   state_nxt = MAC;
      MAC:     if (last_mac) state_nxt = PROP;
      PROP:    if (last_prop) state_nxt = last_i ? SUB : MCALC;
      SUB:     if (last_sub) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_out <= '0;
    end else begin
      state <= state_nxt;
      // Final borrow set means the pre-subtract value was already below p.
      if (state == SUB && last_sub)
        r_out <= dif[width] ? a[2*S-1:S] : d;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a      <= {{width{1'b0}}, t};
        p_r    <= p;
        pinv_r <= p_inv;
        i      <= '0;
        idx    <= '0;
      end
      MCALC: begin
        m <= prod[width-1:0];
        j <= '0;
        c <= '0;
      end
      MAC, PROP: begin
        a[idx] <= acc[width-1:0];
        c      <= acc[2*width-1:width];
        if (state == MAC) j <= j + JW'(1);
        if (state == PROP && last_prop) begin
          i   <= i + IW'(1);
          idx <= last_i ? IW'(S) : i + IW'(1);
          j   <= '0;
          bor <= 1'b0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
      SUB: if (!last_sub) begin
        d[jl] <= dif[width-1:0];
        bor   <= dif[width];
        j     <= j + JW'(1);
        idx   <= idx + IW'(1);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mont_redc.sv
// Scoreboard bench for mont_redc at width=8, S=2, p=0xFFF1 (R=2^16, R^-1 mod p = 0xEEE1).
module tb_mont_redc;
  localparam int W = 8;
  localparam int S = 2;
  localparam int L = 15;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2*S-1:0][W-1:0] t;
  logic [S-1:0][W-1:0]   p;
  logic [W-1:0]          p_inv;
  logic                  busy, done;
  logic [S-1:0][W-1:0]   r_out;

  typedef struct { logic [15:0] r; int cyc; } exp_t;
  exp_t sb[$];
  int cyc = 0, n_vec = 0, n_err = 0;

  mont_redc #(.width(W), .S(S)) dut (
    .clk(clk), .rst(rst), .start(start), .t(t), .p(p), .p_inv(p_inv),
    .busy(busy), .done(done), .r_out(r_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("r_out", 32'(r_out), 32'(e.r));
        chk("latency", cyc - e.cyc, L);
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] tv, input logic [15:0] rv);
    int k;
    @(negedge clk);
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    if (busy) begin
      n_err++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    t = tv;
    start = 1'b1;
    sb.push_back(exp_t'{r: rv, cyc: cyc});
    n_vec++;
    @(negedge clk);
    start = 1'b0;
    t = 32'h5A5A_A5A5;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] vt [10] = '{32'h0001_0000, 32'h0000_FFF1, 32'hFFF0_FFFF, 32'h0000_0001,
                           32'h0000_000F, 32'hFFF0_0000, 32'h0001_FFE2, 32'h0000_FFF2,
                           32'h0001_0001, 32'h1234_0000};
  logic [15:0] vr [10] = '{16'h0001, 16'h0000, 16'h1110, 16'hEEE1,
                           16'h0001, 16'hFFF0, 16'h0000, 16'hEEE1,
                           16'hEEE2, 16'h1234};
  logic [31:0] bt [3] = '{32'h0005_0000, 32'hFFF0_FFFF, 32'h0000_FFF1};
  logic [15:0] br [3] = '{16'h0005, 16'h1110, 16'h0000};

  initial begin
    t = '0;
    p = 16'hFFF1;
    p_inv = 8'hEF;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_r_out", 32'(r_out), 32'd0);
    rst = 1'b0;

    // t=0 with cycle-by-cycle busy/done profile
    @(negedge clk);
    t = '0;
    start = 1'b1;
    sb.push_back(exp_t'{r: 16'h0000, cyc: cyc});
    n_vec++;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_profile", 32'(busy), 32'd1);
      chk("done_profile", 32'(done), 32'(k == L));
    end
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);

    for (int n = 0; n < 10; n++) begin
      issue(vt[n], vr[n]);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("r_out_hold", 32'(r_out), 32'h1234);

    // reset mid-operation at cycle 7
    @(negedge clk);
    t = 32'h0001_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_r_out", 32'(r_out), 32'd0);
    repeat (30) @(negedge clk);
    issue(32'h0003_0000, 16'h0003);
    wait_idle();

    // start held every cycle: captures only every L+1 cycles
    for (int n = 0; n < 3*(L+1); n++) begin
      start = 1'b1;
      if (n % (L+1) == 0) begin
        t = bt[n/(L+1)];
        sb.push_back(exp_t'{r: br[n/(L+1)], cyc: cyc});
        n_vec++;
      end else begin
        t = 32'h0002_0000;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
